// File: rtl/adc_echo_packer.sv
// adc_echo_packer
//   Frames the ADC sample stream into echoes and scans, packs two samples per
//   bus word and presents the words on a valid/ready interface. The ADC cannot
//   be stalled, so a word that finds the output register occupied is dropped
//   and OVERFLOW is raised.
// Ports
//   ADC_CLK, RESET          : clock, synchronous active-high reset
//   ARM                     : start/restart a scan, latches SAMPLES_PER_ECHO/ECHO_PER_SCAN
//   DIN, DIN_VALID          : sample stream
//   DOUT, DOUT_VALID/READY  : packed word {second, first} with handshake
//   DOUT_EOE, DOUT_EOS      : last word of echo / of scan
//   BUSY, SCAN_DONE         : scan in progress, one-cycle completion pulse
//   OVERFLOW, WORD_CNT      : sticky word-lost flag, accepted word count
module adc_echo_packer #(
  parameter int unsigned ADC_DATA_WIDTH = 16,
  parameter int unsigned DATABUS_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      ADC_CLK,
  input  logic                      RESET,
  input  logic                      ARM,
  input  logic [CNT_WIDTH-1:0]      SAMPLES_PER_ECHO,
  input  logic [CNT_WIDTH-1:0]      ECHO_PER_SCAN,
  input  logic [ADC_DATA_WIDTH-1:0] DIN,
  input  logic                      DIN_VALID,
  output logic [DATABUS_WIDTH-1:0]  DOUT,
  output logic                      DOUT_VALID,
  input  logic                      DOUT_READY,
  output logic                      DOUT_EOE,
  output logic                      DOUT_EOS,
  output logic                      BUSY,
  output logic                      SCAN_DONE,
  output logic                      OVERFLOW,
  output logic [CNT_WIDTH-1:0]      WORD_CNT
);

  typedef enum logic [2:0] {StIdle, StLo, StHi, StDrain, StDone} state_e;

  state_e r_state, w_state_next;

  logic [CNT_WIDTH-1:0]      r_spe, r_eps;
  logic [CNT_WIDTH-1:0]      r_samp_cnt, r_echo_cnt, r_word_cnt;
  logic [ADC_DATA_WIDTH-1:0] r_lo;
  logic [DATABUS_WIDTH-1:0]  r_dout;
  logic                      r_dout_valid, r_dout_eoe, r_dout_eos;
  logic                      r_overflow, r_scan_done;
  // Zero-length scan: keeps BUSY up for one cycle before SCAN_DONE.
  logic                      r_zero_pend;

  logic                      w_cfg_zero, w_take, w_last_samp, w_last_echo;
  logic                      w_complete, w_eos, w_accept, w_can_load, w_load, w_drop;
  logic [DATABUS_WIDTH-1:0]  w_word;

  assign w_cfg_zero  = (SAMPLES_PER_ECHO == '0) || (ECHO_PER_SCAN == '0);
  assign w_take      = DIN_VALID && !ARM && ((r_state == StLo) || (r_state == StHi));
  assign w_last_samp = ((r_samp_cnt + CNT_WIDTH'(1)) == r_spe);
  assign w_last_echo = ((r_echo_cnt + CNT_WIDTH'(1)) == r_eps);
  // A word completes on every second sample, or early on an odd echo's last sample.
  assign w_complete  = w_take && ((r_state == StHi) || w_last_samp);
  assign w_eos       = w_complete && w_last_samp && w_last_echo;
  assign w_accept    = r_dout_valid && DOUT_READY;
  assign w_can_load  = !r_dout_valid || DOUT_READY;
  assign w_load      = w_complete && w_can_load;
  assign w_drop      = w_complete && !w_can_load;
  assign w_word      = (r_state == StHi) ? {DIN, r_lo} : {{ADC_DATA_WIDTH{1'b0}}, DIN};

  // State register
  always_ff @(posedge ADC_CLK) begin
    if (RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (ARM) begin
      w_state_next = w_cfg_zero ? StDone : StLo;
    end else begin
      unique case (r_state)
        StLo, StHi: begin
          if (w_take) begin
            if (w_last_samp && w_last_echo) begin
              // A dropped final word has nothing left to drain.
              w_state_next = w_can_load ? StDrain : StDone;
            end else if (r_state == StHi || w_last_samp) begin
              w_state_next = StLo;
            end else begin
              w_state_next = StHi;
            end
          end
        end
        StDrain: begin
          if (w_accept) w_state_next = StDone;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // Outputs
  always_comb begin
    DOUT       = r_dout;
    DOUT_VALID = r_dout_valid;
    DOUT_EOE   = r_dout_eoe;
    DOUT_EOS   = r_dout_eos;
    OVERFLOW   = r_overflow;
    WORD_CNT   = r_word_cnt;
    SCAN_DONE  = r_scan_done;
    BUSY       = r_zero_pend || (r_state == StLo) || (r_state == StHi) ||
                 (r_state == StDrain);
  end

  // Datapath, counters and flags
  always_ff @(posedge ADC_CLK) begin
    if (RESET) begin
      r_spe        <= '0;
      r_eps        <= '0;
      r_samp_cnt   <= '0;
      r_echo_cnt   <= '0;
      r_word_cnt   <= '0;
      r_lo         <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_eoe   <= 1'b0;
      r_dout_eos   <= 1'b0;
      r_overflow   <= 1'b0;
      r_scan_done  <= 1'b0;
      r_zero_pend  <= 1'b0;
    end else if (ARM) begin
      r_spe        <= SAMPLES_PER_ECHO;
      r_eps        <= ECHO_PER_SCAN;
      r_samp_cnt   <= '0;
      r_echo_cnt   <= '0;
      r_word_cnt   <= '0;
      r_overflow   <= 1'b0;
      r_dout_valid <= 1'b0;
      r_scan_done  <= 1'b0;
      r_zero_pend  <= w_cfg_zero;
    end else begin
      r_zero_pend <= 1'b0;
      r_scan_done <= r_zero_pend || ((r_state == StDrain) && w_accept) || (w_drop && w_eos);

      if (w_accept) begin
        r_word_cnt   <= r_word_cnt + CNT_WIDTH'(1);
        r_dout_valid <= 1'b0;
      end

      if (w_take) begin
        if ((r_state == StLo) && !w_last_samp) r_lo <= DIN;
        // Echo boundary: next echo starts word-aligned.
        if (w_last_samp) begin
          r_samp_cnt <= '0;
          r_echo_cnt <= r_echo_cnt + CNT_WIDTH'(1);
        end else begin
          r_samp_cnt <= r_samp_cnt + CNT_WIDTH'(1);
        end
      end

      if (w_load) begin
        r_dout       <= w_word;
        r_dout_eoe   <= w_last_samp;
        r_dout_eos   <= w_eos;
        r_dout_valid <= 1'b1;
      end

      if (w_drop) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_echo_packer.sv
// Testbench for adc_echo_packer: directed scenarios with literal expectations
// plus randomized scans, all checked every cycle against a sample-index model.
module tb_adc_echo_packer;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        ARM = 1'b0;
  logic [31:0] SPE = '0, EPS = '0;
  logic [15:0] DIN = '0;
  logic        DIN_VALID = 1'b0;
  logic        DOUT_READY = 1'b1;
  logic [31:0] DOUT;
  logic        DOUT_VALID, DOUT_EOE, DOUT_EOS, BUSY, SCAN_DONE, OVERFLOW;
  logic [31:0] WORD_CNT;

  adc_echo_packer dut (
    .ADC_CLK         (clk),
    .RESET           (RESET),
    .ARM             (ARM),
    .SAMPLES_PER_ECHO(SPE),
    .ECHO_PER_SCAN   (EPS),
    .DIN             (DIN),
    .DIN_VALID       (DIN_VALID),
    .DOUT            (DOUT),
    .DOUT_VALID      (DOUT_VALID),
    .DOUT_READY      (DOUT_READY),
    .DOUT_EOE        (DOUT_EOE),
    .DOUT_EOS        (DOUT_EOS),
    .BUSY            (BUSY),
    .SCAN_DONE       (SCAN_DONE),
    .OVERFLOW        (OVERFLOW),
    .WORD_CNT        (WORD_CNT)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (sample-index arithmetic) ----------------
  longint unsigned m_spe, m_eps, m_total, m_n;
  logic [15:0] m_lo;
  logic [31:0] m_d, m_wcnt;
  bit m_v, m_eoe, m_eos, m_ovf, m_sd;
  bit m_coll, m_final, m_zero_pend, m_busy;

  always @(posedge clk) begin
    bit acc, canload, compl, eoe, eos;
    logic [31:0] w;
    longint unsigned pos;
    acc     = m_v && DOUT_READY;
    canload = !m_v || DOUT_READY;
    w       = '0;
    if (RESET) begin
      m_spe = 0; m_eps = 0; m_total = 0; m_n = 0; m_lo = '0; m_d = '0; m_wcnt = '0;
      m_v = 0; m_eoe = 0; m_eos = 0; m_ovf = 0; m_sd = 0;
      m_coll = 0; m_final = 0; m_zero_pend = 0;
    end else if (ARM) begin
      m_spe = SPE; m_eps = EPS; m_total = m_spe * m_eps; m_n = 0;
      m_wcnt = '0; m_ovf = 0; m_v = 0; m_sd = 0; m_final = 0;
      m_zero_pend = (SPE == 0) || (EPS == 0);
      m_coll = !m_zero_pend;
    end else begin
      m_sd = m_zero_pend;
      m_zero_pend = 0;
      if (acc) begin
        m_wcnt = m_wcnt + 1;
        m_v = 0;
        if (m_final) begin m_final = 0; m_sd = 1; end
      end
      if (m_coll && DIN_VALID) begin
        compl = 0;
        pos = m_n % m_spe;
        eoe = (pos == m_spe - 1);
        if (pos % 2 == 1) begin
          w = {DIN, m_lo}; compl = 1;
        end else begin
          m_lo = DIN;
          if (eoe) begin w = {16'h0000, DIN}; compl = 1; end
        end
        m_n++;
        eos = (m_n == m_total);
        if (compl) begin
          if (canload) begin
            m_d = w; m_eoe = eoe; m_eos = eos; m_v = 1;
            if (eos) begin m_coll = 0; m_final = 1; end
          end else begin
            m_ovf = 1;
            if (eos) begin m_coll = 0; m_sd = 1; end
          end
        end
      end
    end
    m_busy = m_coll || m_final || m_zero_pend;
  end

  // ---------------- compare process + acceptance log ----------------
  typedef struct packed {logic [31:0] d; logic eoe; logic eos;} acc_t;
  acc_t q[$];
  int n_sd = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("dout_valid", DOUT_VALID, m_v);
      cmp("word_cnt", WORD_CNT, m_wcnt);
      cmp("overflow", OVERFLOW, m_ovf);
      cmp("busy", BUSY, m_busy);
      cmp("scan_done", SCAN_DONE, m_sd);
      if (m_v) begin
        cmp("dout", DOUT, m_d);
        cmp("dout_eoe", DOUT_EOE, m_eoe);
        cmp("dout_eos", DOUT_EOS, m_eos);
      end
      if (DOUT_VALID && DOUT_READY) q.push_back({DOUT, DOUT_EOE, DOUT_EOS});
      if (SCAN_DONE) n_sd++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic arm(input logic [31:0] s, input logic [31:0] e);
    ARM = 1'b1; SPE = s; EPS = e; DIN_VALID = 1'b0;
    tick();
    ARM = 1'b0;
  endtask

  task automatic sample(input logic [15:0] d);
    DIN = d; DIN_VALID = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    DIN_VALID = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_b_words(input string tag, input int base);
    logic [31:0] exp_d [4];
    logic [1:0]  exp_f [4];
    exp_d[0] = 32'h0002_0001; exp_f[0] = 2'b00;
    exp_d[1] = 32'h0000_0003; exp_f[1] = 2'b10;
    exp_d[2] = 32'h0005_0004; exp_f[2] = 2'b00;
    exp_d[3] = 32'h0000_0006; exp_f[3] = 2'b11;
    cmp({tag, "_nwords"}, q.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < q.size()) begin
        cmp({tag, "_word"}, q[base+i].d, exp_d[i]);
        cmp({tag, "_flags"}, {q[base+i].eoe, q[base+i].eos}, exp_f[i]);
      end
    end
  endtask

  initial begin
    int base, sd0, cyc;
    // Reset
    RESET = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    cmp("rst_valid", DOUT_VALID, 0);
    cmp("rst_busy", BUSY, 0);
    cmp("rst_wcnt", WORD_CNT, 0);
    cmp("rst_dout", DOUT, 0);
    RESET = 1'b0;
    idle(2);

    // A: 30 samples x 5 echoes, free-flowing consumer
    base = q.size(); sd0 = n_sd;
    arm(30, 5);
    for (int k = 0; k < 150; k++) sample(16'(100 + k));
    idle(5);
    cmp("A_nwords", q.size() - base, 75);
    if (q.size() > base) cmp("A_first", q[base].d, 32'h0065_0064);
    for (int i = 0; i < 75; i++) begin
      if (base + i < q.size()) begin
        cmp("A_eoe", q[base+i].eoe, ((i + 1) % 15) == 0);
        cmp("A_eos", q[base+i].eos, i == 74);
      end
    end
    cmp("A_wcnt", WORD_CNT, 75);
    cmp("A_scan_done", n_sd - sd0, 1);
    cmp("A_overflow", OVERFLOW, 0);

    // B: odd echo length pads the high half
    base = q.size(); sd0 = n_sd;
    arm(3, 2);
    for (int k = 1; k <= 6; k++) sample(16'(k));
    idle(4);
    check_b_words("B", base);
    cmp("B_scan_done", n_sd - sd0, 1);

    // C: consumer stalls 40 cycles from the first word
    base = q.size(); sd0 = n_sd;
    arm(30, 5);
    sample(16'd100);
    sample(16'd101);
    DOUT_READY = 1'b0;
    for (int k = 2; k < 42; k++) sample(16'(100 + k));
    DOUT_READY = 1'b1;
    for (int k = 42; k < 150; k++) sample(16'(100 + k));
    idle(5);
    cmp("C_overflow", OVERFLOW, 1);
    if (q.size() > base) cmp("C_first", q[base].d, 32'h0065_0064);
    cmp("C_wcnt_lt75", WORD_CNT < 75, 1);
    cmp("C_scan_done", n_sd - sd0, 1);

    // D: zero echoes per scan
    arm(8, 0);
    cmp("D_busy1", BUSY, 1);
    cmp("D_sd1", SCAN_DONE, 0);
    tick();
    cmp("D_busy2", BUSY, 0);
    cmp("D_sd2", SCAN_DONE, 1);
    cmp("D_valid", DOUT_VALID, 0);
    tick();
    cmp("D_sd3", SCAN_DONE, 0);
    idle(2);

    // E: re-ARM mid-echo
    sd0 = n_sd;
    arm(30, 5);
    for (int k = 0; k < 7; k++) sample(16'(100 + k));
    arm(3, 2);
    cmp("E_valid", DOUT_VALID, 0);
    cmp("E_wcnt", WORD_CNT, 0);
    base = q.size();
    for (int k = 1; k <= 6; k++) sample(16'(k));
    idle(4);
    check_b_words("E", base);
    cmp("E_scan_done", n_sd - sd0, 1);

    // F: RESET together with ARM mid-scan
    arm(30, 5);
    for (int k = 0; k < 10; k++) sample(16'(k));
    RESET = 1'b1; ARM = 1'b1; DIN_VALID = 1'b1;
    tick();
    RESET = 1'b0; ARM = 1'b0;
    for (int k = 0; k < 10; k++) sample(16'(k + 50));
    cmp("F_busy", BUSY, 0);
    cmp("F_valid", DOUT_VALID, 0);
    cmp("F_wcnt", WORD_CNT, 0);
    cmp("F_dout", DOUT, 0);
    cmp("F_ovf", OVERFLOW, 0);
    idle(2);

    // G: randomized scans with random handshake and occasional aborts
    for (int s = 0; s < 30; s++) begin
      bit abort;
      int abort_at;
      DOUT_READY = 1'b1;
      idle(2);
      arm($urandom_range(0, 9), $urandom_range(0, 4));
      abort = ($urandom_range(0, 4) == 0);
      abort_at = $urandom_range(0, 20);
      cyc = 0;
      while ((m_busy || m_v) && cyc < 3000) begin
        DIN = 16'($urandom);
        DIN_VALID = ($urandom_range(0, 9) < 7);
        DOUT_READY = ($urandom_range(0, 9) < 6);
        if (abort && cyc == abort_at && m_busy) begin
          ARM = 1'b1;
          SPE = $urandom_range(1, 9);
          EPS = $urandom_range(1, 4);
        end
        tick();
        ARM = 1'b0;
        cyc++;
      end
      if (cyc >= 3000) begin
        n_vec++; n_err++;
        $display("FAIL G_timeout: scan %0d still busy after %0d cycles, required idle", s, cyc);
      end
    end
    DOUT_READY = 1'b1;
    idle(3);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_echo_packer.md
Name: adc_echo_packer

Overview:
Downstream consumer of the NMR controller's ADC_OUT_DATA/ADC_DATA_VALID stream, in the ADC_CLK domain. It frames the sample stream into echoes and scans using SAMPLES_PER_ECHO and ECHO_PER_SCAN. It packs two 16-bit samples into each 32-bit bus word and presents words on a valid/ready interface toward the acquisition FIFO/DMA. Each word carries end-of-echo and end-of-scan flags. Overflow is reported, never stalled upstream (the ADC cannot be back-pressured).

Parameters:
ADC_DATA_WIDTH, 16, sample width; must equal DATABUS_WIDTH/2
DATABUS_WIDTH, 32, output word width
CNT_WIDTH, 32, width of sample/echo/word counters and config inputs

Ports:
ADC_CLK  in  1  sole clock, rising edge
RESET  in  1  synchronous, active-high reset
ARM  in  1  one-cycle pulse: latch config, clear counters/flags, start a scan
SAMPLES_PER_ECHO  in  CNT_WIDTH  samples per echo, sampled on ARM
ECHO_PER_SCAN  in  CNT_WIDTH  echoes per scan, sampled on ARM
DIN  in  ADC_DATA_WIDTH  sample (ADC_OUT_DATA)
DIN_VALID  in  1  sample strobe (ADC_DATA_VALID)
DOUT  out  DATABUS_WIDTH  packed word {second sample, first sample}
DOUT_VALID  out  1  DOUT holds an unaccepted word
DOUT_READY  in  1  consumer accepts when DOUT_VALID&&DOUT_READY
DOUT_EOE  out  1  DOUT is last word of an echo
DOUT_EOS  out  1  DOUT is last word of the scan (implies DOUT_EOE)
BUSY  out  1  scan in progress
SCAN_DONE  out  1  one-cycle pulse when EOS word is accepted
OVERFLOW  out  1  sticky: a completed word was lost
WORD_CNT  out  CNT_WIDTH  words accepted since ARM

Behaviour:
- Reset: all outputs 0, state IDLE, config registers 0. RESET overrides ARM and all other inputs.
- States: IDLE, LO (expect first sample of pair), HI (expect second sample), DRAIN (final word waiting), DONE.
- IDLE/DONE + ARM: latch config and clear WORD_CNT, OVERFLOW, and the sample/echo counters; BUSY=1 next cycle.
  - If either config value is 0: go to DONE, pulse SCAN_DONE on the next cycle, emit no words.
  - Otherwise go to LO.
- ARM while BUSY: abort and restart as above. The partial word is discarded, DOUT_VALID cleared same edge, no SCAN_DONE for the aborted scan.
- DIN_VALID is ignored in IDLE, DRAIN and DONE, and in the ARM cycle.
- LO + DIN_VALID: DIN into low half; sample count +1.
  - If it is the last sample of the echo (odd SAMPLES_PER_ECHO), complete the word with high half 0x0000 and EOE=1.
  - Else go to HI.
- HI + DIN_VALID: DIN into high half; complete the word; go to LO. EOE=1 if it is the echo's last sample.
- Each echo starts word-aligned; sample counter resets and echo counter increments at echo end. Words per echo = ceil(SAMPLES_PER_ECHO/2).
- Completed word loads into the DOUT register on the edge after the completing DIN_VALID cycle (latency 1), with DOUT_EOE and DOUT_EOS.
  - EOS=1 on the last echo's last word; state then goes to DRAIN.
- Output register is single-entry:
  - Load allowed if DOUT_VALID=0, or if DOUT_VALID&&DOUT_READY in the same cycle (back-to-back).
  - Otherwise the new word is dropped, OVERFLOW sets (sticky until ARM/RESET), and framing counters still advance.
  - A dropped EOS word moves to DONE and pulses SCAN_DONE immediately.
- Handshake: DOUT/flags stable while DOUT_VALID&&!DOUT_READY. DOUT_VALID falls after acceptance unless a new word loads.
- WORD_CNT +1 per accepted word; wraps modulo 2^CNT_WIDTH.
- DRAIN: when the EOS word is accepted, SCAN_DONE pulses the next cycle, BUSY falls in that same cycle, state goes to DONE.
- Counters compare with equality against latched config; config input changes mid-scan have no effect.

Test Plan:
- SAMPLES_PER_ECHO=30, ECHO_PER_SCAN=5, DIN=100,101,… every cycle, DOUT_READY=1 -> 75 words; first DOUT=0x00650064; EOE on words 15,30,…,75; EOS only on word 75; WORD_CNT=75; one SCAN_DONE pulse; OVERFLOW=0.
- SAMPLES_PER_ECHO=3, ECHO_PER_SCAN=2, DIN=1..6 -> words 0x00020001, 0x00000003(EOE), 0x00050004, 0x00000006(EOE,EOS).
- Same as the first case with DOUT_READY=0 for 40 cycles from the first word -> OVERFLOW=1, first word held unchanged, later words resume, WORD_CNT<75, SCAN_DONE still pulses.
- ARM with ECHO_PER_SCAN=0 -> no DOUT_VALID, SCAN_DONE pulse 2 cycles after ARM, BUSY=1 for 1 cycle.
- ARM mid-echo (after 7 samples) -> DOUT_VALID=0 next cycle, WORD_CNT=0, new scan framing restarts at LO, no stale half-word in first new word.
- RESET asserted mid-scan together with ARM -> all outputs 0, state IDLE, DIN_VALID ignored until next ARM.
